// File: rtl/st7735_init_sequencer.sv
// st7735_init_sequencer: drives the ST7735 hardware reset pulse, then walks an
// init ROM of {CMD, HDR, args, DLY} records and hands each byte to the SPI byte
// engine over a valid/ready handshake with DC and end-of-command marking.
module st7735_init_sequencer #(
    parameter int CLOCK_SPEED_MHZ = 12,
    parameter int ROM_AW          = 8,
    parameter int RESET_LOW_MS    = 10,
    parameter int RESET_WAIT_MS   = 120
) (
    input  logic              SYSTEM_CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              LCD_RESET_N,
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  logic [7:0]        ROM_DATA,
    output logic              TX_VALID,
    output logic [7:0]        TX_DATA,
    output logic              TX_DC,
    output logic              TX_LAST,
    input  logic              TX_READY
);

    localparam int TICK  = CLOCK_SPEED_MHZ * 1000;
    localparam int PRE_W = $clog2(TICK + 1);
    localparam int MS_W  = 16;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HW_LOW, S_HW_WAIT, S_RD_N, S_RD_CMD, S_RD_HDR, S_SEND_CMD,
        S_RD_ARG, S_SEND_ARG, S_RD_DLY, S_DELAY, S_NEXT, S_FIN
    } state_t;

    state_t              r_state, w_state;
    logic                r_ph, w_ph;          // ROM read phase: 0 = address settling, 1 = sample
    logic [ROM_AW-1:0]   r_addr, w_addr;
    logic [7:0]          r_n, w_n;            // commands remaining
    logic [7:0]          r_cmd, w_cmd;
    logic [3:0]          r_argc, w_argc;      // arguments still to send
    logic                r_dly, w_dly;        // a delay byte follows the arguments
    logic [PRE_W-1:0]    r_pre, w_pre;        // 1 ms prescaler
    logic [MS_W-1:0]     r_ms, w_ms;          // milliseconds left in a timed state
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_lcd, w_lcd;
    logic                r_tx_valid, w_tx_valid;
    logic [7:0]          r_tx_data, w_tx_data;
    logic                r_tx_dc, w_tx_dc;
    logic                r_tx_last, w_tx_last;
    logic                w_tick;
    logic                w_ms_last;

    assign w_tick    = (r_pre == PRE_MAX);
    assign w_ms_last = (r_ms <= MS_W'(1));

    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign LCD_RESET_N = r_lcd;
    assign ROM_ADDR    = r_addr;
    assign TX_VALID    = r_tx_valid;
    assign TX_DATA     = r_tx_data;
    assign TX_DC       = r_tx_dc;
    assign TX_LAST     = r_tx_last;

    // State and datapath registers; reset returns every output to its idle value.
    always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_ph       <= 1'b0;
            r_addr     <= '0;
            r_n        <= '0;
            r_cmd      <= '0;
            r_argc     <= '0;
            r_dly      <= 1'b0;
            r_pre      <= '0;
            r_ms       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lcd      <= 1'b1;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_dc    <= 1'b0;
            r_tx_last  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ph       <= w_ph;
            r_addr     <= w_addr;
            r_n        <= w_n;
            r_cmd      <= w_cmd;
            r_argc     <= w_argc;
            r_dly      <= w_dly;
            r_pre      <= w_pre;
            r_ms       <= w_ms;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_lcd      <= w_lcd;
            r_tx_valid <= w_tx_valid;
            r_tx_data  <= w_tx_data;
            r_tx_dc    <= w_tx_dc;
            r_tx_last  <= w_tx_last;
        end
    end

    // Next-state and next-register logic; ROM reads take two cycles (settle, sample).
    always_comb begin
        w_state    = r_state;
        w_ph       = r_ph;
        w_addr     = r_addr;
        w_n        = r_n;
        w_cmd      = r_cmd;
        w_argc     = r_argc;
        w_dly      = r_dly;
        w_pre      = w_tick ? '0 : r_pre + 1'b1;
        w_ms       = r_ms;
        w_busy     = r_busy;
        w_done     = r_done;
        w_lcd      = r_lcd;
        w_tx_valid = r_tx_valid;
        w_tx_data  = r_tx_data;
        w_tx_dc    = r_tx_dc;
        w_tx_last  = r_tx_last;

        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state = S_HW_LOW;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_addr  = '0;
                    w_lcd   = 1'b0;
                    w_pre   = '0;
                    w_ms    = MS_W'(RESET_LOW_MS);
                end
            end
            S_HW_LOW: begin
                if (w_tick) begin
                    if (w_ms_last) begin
                        w_state = S_HW_WAIT;
                        w_lcd   = 1'b1;
                        w_pre   = '0;
                        w_ms    = MS_W'(RESET_WAIT_MS);
                    end else begin
                        w_ms = r_ms - 1'b1;
                    end
                end
            end
            S_HW_WAIT: begin
                if (w_tick) begin
                    if (w_ms_last) begin
                        w_state = S_RD_N;
                        w_ph    = 1'b0;
                    end else begin
                        w_ms = r_ms - 1'b1;
                    end
                end
            end
            S_RD_N: begin
                w_ph = ~r_ph;
                if (r_ph) begin
                    w_addr  = r_addr + 1'b1;
                    w_n     = ROM_DATA;
                    w_state = (ROM_DATA == 8'd0) ? S_FIN : S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                w_ph = ~r_ph;
                if (r_ph) begin
                    w_addr  = r_addr + 1'b1;
                    w_cmd   = ROM_DATA;
                    w_state = S_RD_HDR;
                end
            end
            S_RD_HDR: begin
                w_ph = ~r_ph;
                if (r_ph) begin
                    w_addr     = r_addr + 1'b1;
                    w_dly      = ROM_DATA[7];
                    w_argc     = ROM_DATA[3:0];
                    w_state    = S_SEND_CMD;
                    w_tx_valid = 1'b1;
                    w_tx_data  = r_cmd;
                    w_tx_dc    = 1'b0;
                    w_tx_last  = (ROM_DATA[3:0] == 4'd0);
                end
            end
            S_SEND_CMD: begin
                if (TX_READY) begin
                    w_tx_valid = 1'b0;
                    if (r_argc != 4'd0) w_state = S_RD_ARG;
                    else                w_state = r_dly ? S_RD_DLY : S_NEXT;
                end
            end
            S_RD_ARG: begin
                w_ph = ~r_ph;
                if (r_ph) begin
                    w_addr     = r_addr + 1'b1;
                    w_state    = S_SEND_ARG;
                    w_tx_valid = 1'b1;
                    w_tx_data  = ROM_DATA;
                    w_tx_dc    = 1'b1;
                    w_tx_last  = (r_argc == 4'd1);
                end
            end
            S_SEND_ARG: begin
                if (TX_READY) begin
                    w_tx_valid = 1'b0;
                    w_argc     = r_argc - 1'b1;
                    if (r_argc != 4'd1) w_state = S_RD_ARG;
                    else                w_state = r_dly ? S_RD_DLY : S_NEXT;
                end
            end
            S_RD_DLY: begin
                w_ph = ~r_ph;
                if (r_ph) begin
                    w_addr = r_addr + 1'b1;
                    if (ROM_DATA == 8'd0) begin
                        w_state = S_NEXT;
                    end else begin
                        w_state = S_DELAY;
                        w_pre   = '0;
                        w_ms    = (ROM_DATA == 8'hFF) ? MS_W'(500) : MS_W'(ROM_DATA);
                    end
                end
            end
            S_DELAY: begin
                if (w_tick) begin
                    if (w_ms_last) w_state = S_NEXT;
                    else           w_ms    = r_ms - 1'b1;
                end
            end
            S_NEXT: begin
                w_n     = r_n - 1'b1;
                w_state = (r_n == 8'd1) ? S_FIN : S_RD_CMD;
            end
            S_FIN: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

endmodule
